// File: rtl/arbiter_out_credit.sv
// rtl/arbiter_out_credit.sv - per-output round-robin packet allocator with downstream credit gating
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   req[4:0]    per-input request for this output (bit0=N, 1=E, 2=W, 3=S, 4=L)
//   empty[4:0]  per-input FIFO empty
//   tail[4:0]   per-input head flit is a tail flit
//   credit_in   one-cycle pulse: downstream freed one slot
//   grant[4:0]  registered one-hot (or zero) grant; crossbar select and FIFO pop
//   valid_out   a flit transfers this cycle
//   credit_cnt  current downstream credit count
//   err_credit  sticky: credit returned while counter already full
module arbiter_out_credit #(
    parameter int CREDIT_MAX = 4,
    parameter int CW         = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    req,
    input  logic [4:0]    empty,
    input  logic [4:0]    tail,
    input  logic          credit_in,
    output logic [4:0]    grant,
    output logic          valid_out,
    output logic [CW-1:0] credit_cnt,
    output logic          err_credit
);

    localparam logic [CW-1:0] CMAX = CW'(CREDIT_MAX);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state, state_nx;
    logic [4:0] grant_nx;
    logic [2:0] rr_ptr, rr_nx;
    logic [2:0] gidx;
    logic [2:0] win;
    logic       win_found;
    logic [3:0] idx;
    logic       xfer;
    logic       xfer_tail;

    // Index of the currently granted input (grant is one-hot while BUSY).
    always_comb begin
        gidx = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (grant[i]) gidx = 3'(i);
        end
    end

    // Round-robin pick: first requester at or after rr_ptr, wrapping 4 -> 0.
    always_comb begin
        win       = rr_ptr;
        win_found = 1'b0;
        idx       = 4'd0;
        for (int k = 0; k < 5; k++) begin
            idx = {1'b0, rr_ptr} + 4'(k);
            if (idx >= 4'd5) idx = idx - 4'd5;
            if (!win_found && req[idx[2:0]]) begin
                win       = idx[2:0];
                win_found = 1'b1;
            end
        end
    end

    // grant is only nonzero in BUSY, so no explicit state term is needed for
    // the data path; it is kept for clarity of intent.
    assign xfer      = (state == BUSY) && ((grant & ~empty) != 5'd0) && (credit_cnt != '0);
    assign xfer_tail = xfer && ((grant & tail) != 5'd0);
    assign valid_out = xfer;

    always_comb begin
        state_nx = state;
        grant_nx = grant;
        rr_nx    = rr_ptr;
        case (state)
            IDLE: begin
                if (win_found) begin
                    grant_nx = 5'd1 << win;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                // Requests are ignored while BUSY; only a tail transfer releases.
                if (xfer_tail) begin
                    grant_nx = 5'd0;
                    state_nx = IDLE;
                    rr_nx    = (gidx == 3'd4) ? 3'd0 : gidx + 3'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                grant_nx = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            grant  <= 5'd0;
            rr_ptr <= 3'd0;
        end else begin
            state  <= state_nx;
            grant  <= grant_nx;
            rr_ptr <= rr_nx;
        end
    end

    // A simultaneous transfer and credit return cancel out. A return at full
    // count is dropped and flagged, since it means upstream/downstream disagree.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit_cnt <= CMAX;
            err_credit <= 1'b0;
        end else begin
            case ({xfer, credit_in})
                2'b10: credit_cnt <= credit_cnt - 1'b1;
                2'b01: begin
                    if (credit_cnt == CMAX) err_credit <= 1'b1;
                    else                    credit_cnt <= credit_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(grant));
    a_grant_busy:   assert property (@(posedge clk) disable iff (!rst) ((grant != 5'd0) == (state == BUSY)));
    a_credit_max:   assert property (@(posedge clk) disable iff (!rst) (credit_cnt <= CMAX));
    a_valid_src:    assert property (@(posedge clk) disable iff (!rst) (valid_out |-> ((grant & ~empty) != 5'd0)));

endmodule

// File: tb/tb_arbiter_out_credit.sv
// tb/tb_arbiter_out_credit.sv - self-checking bench for arbiter_out_credit
module tb_arbiter_out_credit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] req, empty, tail;
    logic       credit_in;
    logic [4:0] grant;
    logic       valid_out;
    logic [2:0] credit_cnt;
    logic       err_credit;

    int n_total = 0;
    int n_pass  = 0;

    arbiter_out_credit #(.CREDIT_MAX(4), .CW(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .empty      (empty),
        .tail       (tail),
        .credit_in  (credit_in),
        .grant      (grant),
        .valid_out  (valid_out),
        .credit_cnt (credit_cnt),
        .err_credit (err_credit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] req;
        logic [4:0] empty;
        logic [4:0] tail;
        logic       cin;
        logic [4:0] g;
        logic       v;
        logic [2:0] cnt;
        logic       err;
    } vec_t;

    vec_t vt[13];

    // Reference model: packet owner, the last input served, credits as an integer.
    int m_owner;
    int m_last;
    int m_cred;
    bit m_err;

    task automatic model_reset();
        m_owner = -1;
        m_last  = 4;
        m_cred  = 4;
        m_err   = 0;
    endtask

    function automatic logic [4:0] model_grant();
        return (m_owner >= 0) ? 5'(1 << m_owner) : 5'd0;
    endfunction

    function automatic bit model_valid();
        return (m_owner >= 0) && !empty[m_owner] && (m_cred > 0);
    endfunction

    task automatic model_step();
        bit v;
        v = model_valid();
        if (v && credit_in) m_cred = m_cred;
        else if (v)         m_cred = m_cred - 1;
        else if (credit_in) begin
            if (m_cred == 4) m_err = 1;
            else             m_cred = m_cred + 1;
        end
        if (m_owner >= 0) begin
            if (v && tail[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end else begin
            for (int k = 1; k <= 5; k++) begin
                if (m_owner < 0 && req[(m_last + k) % 5]) m_owner = (m_last + k) % 5;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input logic [4:0] r, input logic [4:0] e, input logic [4:0] t, input logic c);
        req = r; empty = e; tail = t; credit_in = c;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(5'd0, 5'd0, 5'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
    endtask

    int xfers;

    initial begin
        rst = 1'b0;
        req = '0; empty = '0; tail = '0; credit_in = 1'b0;

        //             req       empty     tail      cin    grant     v     cnt   err
        vt[0]  = '{5'b00100, 5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0, 3'd4, 1'b0};
        vt[1]  = '{5'b00100, 5'b00000, 5'b00000, 1'b0, 5'b00100, 1'b1, 3'd4, 1'b0};
        vt[2]  = '{5'b00100, 5'b00000, 5'b00000, 1'b0, 5'b00100, 1'b1, 3'd3, 1'b0};
        vt[3]  = '{5'b00100, 5'b00000, 5'b00100, 1'b0, 5'b00100, 1'b1, 3'd2, 1'b0};
        vt[4]  = '{5'b00101, 5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0, 3'd1, 1'b0};
        vt[5]  = '{5'b00101, 5'b00000, 5'b00001, 1'b1, 5'b00001, 1'b1, 3'd1, 1'b0};
        vt[6]  = '{5'b00101, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd1, 1'b0};
        vt[7]  = '{5'b00101, 5'b11111, 5'b00000, 1'b0, 5'b00100, 1'b0, 3'd2, 1'b0};
        vt[8]  = '{5'b00101, 5'b00000, 5'b00100, 1'b1, 5'b00100, 1'b1, 3'd2, 1'b0};
        vt[9]  = '{5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd2, 1'b0};
        vt[10] = '{5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd3, 1'b0};
        vt[11] = '{5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd4, 1'b0};
        vt[12] = '{5'b00000, 5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0, 3'd4, 1'b1};

        // Table-driven: single W packet, rr_ptr advance, stall, credit corner cases.
        @(negedge clk);
        do_reset();
        chk("reset_grant", 32'(grant), 32'd0);
        chk("reset_cnt", 32'(credit_cnt), 32'd4);
        chk("reset_err", 32'(err_credit), 32'd0);
        for (int i = 0; i < 13; i++) begin
            drive(vt[i].req, vt[i].empty, vt[i].tail, vt[i].cin);
            chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(vt[i].g));
            chk($sformatf("vec%0d_valid", i), 32'(valid_out), 32'(vt[i].v));
            chk($sformatf("vec%0d_cnt", i), 32'(credit_cnt), 32'(vt[i].cnt));
            chk($sformatf("vec%0d_err", i), 32'(err_credit), 32'(vt[i].err));
            tick();
        end

        // Round-robin fairness with all inputs requesting 1-flit packets.
        do_reset();
        for (int p = 0; p < 6; p++) begin
            drive(5'b11111, 5'b00000, 5'b11111, 1'b0);
            chk($sformatf("rr%0d_idle", p), 32'(grant), 32'd0);
            tick();
            drive(5'b11111, 5'b00000, 5'b11111, 1'b1);
            chk($sformatf("rr%0d_grant", p), 32'(grant), 32'(1 << (p % 5)));
            chk($sformatf("rr%0d_valid", p), 32'(valid_out), 32'd1);
            tick();
        end
        chk("rr_cnt", 32'(credit_cnt), 32'd4);

        // Credit exhaustion on a long packet, then a single credit return.
        do_reset();
        drive(5'b00010, 5'b00000, 5'b00000, 1'b0);
        tick();
        xfers = 0;
        for (int i = 0; i < 8; i++) begin
            drive(5'b00010, 5'b00000, 5'b00000, 1'b0);
            if (valid_out) xfers++;
            tick();
        end
        chk("exh_xfers", 32'(xfers), 32'd4);
        drive(5'b00010, 5'b00000, 5'b00000, 1'b1);
        chk("exh_grant", 32'(grant), 32'b00010);
        chk("exh_cnt", 32'(credit_cnt), 32'd0);
        chk("exh_valid_cin", 32'(valid_out), 32'd0);
        tick();
        drive(5'b00010, 5'b00000, 5'b00000, 1'b0);
        chk("exh_resume", 32'(valid_out), 32'd1);
        chk("exh_err", 32'(err_credit), 32'd0);
        tick();
        chk("exh_cnt_after", 32'(credit_cnt), 32'd0);

        // Empty stall mid-packet while other inputs request.
        do_reset();
        drive(5'b00001, 5'b00000, 5'b00000, 1'b0);
        tick();
        drive(5'b00001, 5'b00000, 5'b00000, 1'b0);
        chk("stall_first", 32'(valid_out), 32'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(5'b11110, 5'b00001, 5'b00000, 1'b0);
            chk($sformatf("stall%0d_grant", i), 32'(grant), 32'b00001);
            chk($sformatf("stall%0d_valid", i), 32'(valid_out), 32'd0);
            tick();
        end
        drive(5'b11110, 5'b00000, 5'b00001, 1'b0);
        chk("stall_tail_valid", 32'(valid_out), 32'd1);
        chk("stall_tail_grant", 32'(grant), 32'b00001);
        tick();
        drive(5'b11110, 5'b00000, 5'b00000, 1'b0);
        chk("stall_idle", 32'(grant), 32'd0);
        tick();
        chk("stall_next", 32'(grant), 32'b00010);

        // Asynchronous reset mid-packet with one credit left.
        do_reset();
        drive(5'b01000, 5'b00000, 5'b00000, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(5'b01000, 5'b00000, 5'b00000, 1'b0);
            tick();
        end
        chk("ar_pre_cnt", 32'(credit_cnt), 32'd1);
        chk("ar_pre_grant", 32'(grant), 32'b01000);
        rst = 1'b0;
        #1;
        chk("ar_grant", 32'(grant), 32'd0);
        chk("ar_cnt", 32'(credit_cnt), 32'd4);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        drive(5'b00000, 5'b00000, 5'b00000, 1'b0);
        tick();
        chk("ar_idle_grant", 32'(grant), 32'd0);
        chk("ar_idle_valid", 32'(valid_out), 32'd0);

        // Randomised run against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 600 == 599) do_reset();
            drive(5'($urandom),
                  5'($urandom & $urandom),
                  5'($urandom & $urandom),
                  1'($urandom_range(0, 9) < 4));
            chk($sformatf("rnd%0d_grant", c), 32'(grant), 32'(model_grant()));
            chk($sformatf("rnd%0d_valid", c), 32'(valid_out), 32'(model_valid()));
            chk($sformatf("rnd%0d_cnt", c), 32'(credit_cnt), 32'(m_cred));
            chk($sformatf("rnd%0d_err", c), 32'(err_credit), 32'(m_err));
            model_step();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
